// File: rtl/lp_sync_pkg.sv
// lp_sync_pkg: shared constants and helpers for the LP-line synchroniser/filter.
//   LP_SYNC_MAX_STAGES : deepest synchroniser chain supported
//   LP_SYNC_MAX_FILTER : longest persistence filter supported
//   LP_GLITCH_CNT_W    : width of each per-channel glitch counter
//   lp_cnt_w()         : filter counter width for a given FILTER_LEN
package lp_sync_pkg;
    localparam int LP_SYNC_MAX_STAGES = 4;
    localparam int LP_SYNC_MAX_FILTER = 15;
    localparam int LP_GLITCH_CNT_W    = 4;

    function automatic int lp_cnt_w(input int filter_len);
        return $clog2(filter_len + 1);
    endfunction
endpackage

// File: rtl/lp_sync_chan.sv
// lp_sync_chan: one LP-line channel -- sync chain, persistence filter,
// registered edge pulses and (optionally) a saturating glitch counter.
// Optional feature macro: LP_SYNC_GLITCH_CNT_EN (adds glitch_cnt).
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   async_in    : unsynchronised input bit
//   stable_out  : synchronised, filtered level
//   rise, fall  : 1-cycle pulses aligned with stable_out changing
//   change      : combinational "stable_out updates at the next edge",
//                 lets the top register any_change in step with rise/fall
//   glitch_cnt  : count of rejected runs, saturating (macro only)
module lp_sync_chan
    import lp_sync_pkg::*;
#(
    parameter int   STAGES     = 2,
    parameter int   FILTER_LEN = 4,
    parameter logic RESET_BIT  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic stable_out,
    output logic rise,
    output logic fall,
`ifdef LP_SYNC_GLITCH_CNT_EN
    output logic [LP_GLITCH_CNT_W-1:0] glitch_cnt,
`endif
    output logic change
);
    localparam int               CNT_W    = lp_cnt_w(FILTER_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [STAGES-1:0] s;
    logic [CNT_W-1:0]  cnt;
    logic              syn;
    logic              differ;
    logic              take;

    assign syn    = s[STAGES-1];
    assign differ = syn ^ stable_out;
    // The run has persisted FILTER_LEN samples once this edge lands.
    assign take   = differ && (cnt == CNT_LAST);
    assign change = take;

    // Plain flop chain: nothing may sit between stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) s <= {STAGES{RESET_BIT}};
        else     s <= {s[STAGES-2:0], async_in};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            stable_out <= RESET_BIT;
            rise       <= 1'b0;
            fall       <= 1'b0;
        end else begin
            rise <= take & syn;
            fall <= take & ~syn;
            if (!differ) begin
                cnt <= '0;
            end else if (take) begin
                stable_out <= syn;
                cnt        <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

`ifdef LP_SYNC_GLITCH_CNT_EN
    // A rejected run ends when the input agrees again with a count pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            glitch_cnt <= '0;
        else if (!differ && (cnt != '0) && (glitch_cnt != '1))
            glitch_cnt <= glitch_cnt + LP_GLITCH_CNT_W'(1);
    end
`endif
endmodule

// File: rtl/lp_sync_filter.sv
// lp_sync_filter: WIDTH independent LP-line synchronisers with glitch filter.
// Optional feature macro: LP_SYNC_GLITCH_CNT_EN (adds glitch_cnt port).
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   async_in    : WIDTH unsynchronised inputs
//   stable_out  : WIDTH synchronised, filtered levels (reset to RESET_VAL)
//   rise, fall  : WIDTH 1-cycle edge pulses
//   any_change  : registered OR of rise|fall, aligned with them
//   glitch_cnt  : 4 bits per channel, channel i at [4i+3:4i] (macro only)
module lp_sync_filter
    import lp_sync_pkg::*;
#(
    parameter int               WIDTH      = 2,
    parameter int               STAGES     = 2,
    parameter int               FILTER_LEN = 4,
    parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] stable_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
`ifdef LP_SYNC_GLITCH_CNT_EN
    output logic [WIDTH*LP_GLITCH_CNT_W-1:0] glitch_cnt,
`endif
    output logic             any_change
);
    if (STAGES < 2 || STAGES > LP_SYNC_MAX_STAGES) begin : g_bad_stages
        $error("lp_sync_filter: STAGES must be 2..4");
    end
    if (FILTER_LEN < 1 || FILTER_LEN > LP_SYNC_MAX_FILTER) begin : g_bad_filter
        $error("lp_sync_filter: FILTER_LEN must be 1..15");
    end

    logic [WIDTH-1:0] change;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        lp_sync_chan #(
            .STAGES    (STAGES),
            .FILTER_LEN(FILTER_LEN),
            .RESET_BIT (RESET_VAL[i])
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .async_in  (async_in[i]),
            .stable_out(stable_out[i]),
            .rise      (rise[i]),
            .fall      (fall[i]),
`ifdef LP_SYNC_GLITCH_CNT_EN
            .glitch_cnt(glitch_cnt[i*LP_GLITCH_CNT_W +: LP_GLITCH_CNT_W]),
`endif
            .change    (change[i])
        );
    end

    // Registered from the same "take" terms as rise/fall, so it lines up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) any_change <= 1'b0;
        else     any_change <= |change;
    end
endmodule

// File: tb/tb_lp_sync_filter.sv
// tb_lp_sync_filter: scoreboard bench. Each driven step pushes the expected
// pulse (cycle, rise, fall) to a queue; a negedge monitor pops and compares
// whenever the DUT emits a pulse. Level and glitch-count checks are inline.
module tb_lp_sync_filter;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] async_in;
    logic [1:0] stable_out, rise, fall;
    logic       any_change;
`ifdef LP_SYNC_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        logic [1:0] r;
        logic [1:0] f;
    } ev_t;
    ev_t q[$];

    lp_sync_filter #(
        .WIDTH(2), .STAGES(2), .FILTER_LEN(4), .RESET_VAL(2'b11)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .async_in  (async_in),
        .stable_out(stable_out),
        .rise      (rise),
        .fall      (fall),
`ifdef LP_SYNC_GLITCH_CNT_EN
        .glitch_cnt(glitch_cnt),
`endif
        .any_change(any_change)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [1:0] r, input logic [1:0] f);
        ev_t e;
        e.cyc = c; e.r = r; e.f = f;
        q.push_back(e);
    endtask

    // Pulse monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && (rise != 2'b00 || fall != 2'b00 || any_change)) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", {rise, fall, any_change}, 32'd0);
            end else begin
                ev_t e;
                e = q.pop_front();
                chk("ev_cyc",  cyc,        e.cyc);
                chk("ev_rise", rise,       e.r);
                chk("ev_fall", fall,       e.f);
                chk("ev_any",  any_change, 1'b1);
            end
        end
    end

    initial begin
        int c;
        rst      = 1'b1;
        async_in = 2'b00;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_stable", stable_out, 2'b11);
        chk("rst_rise",   rise,       2'b00);
        chk("rst_fall",   fall,       2'b00);
        chk("rst_any",    any_change, 1'b0);
`ifdef LP_SYNC_GLITCH_CNT_EN
        chk("rst_glitch", glitch_cnt, 8'h00);
`endif

        // Release with inputs differing from RESET_VAL: both fall after 6 edges
        rst = 1'b0;
        c = cyc;
        push(c + 6, 2'b00, 2'b11);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("relax_stable", stable_out, (k < 6) ? 2'b11 : 2'b00);
        end
        repeat (4) @(negedge clk);

        // Clean step on ch0
        async_in[0] = 1'b1;
        c = cyc;
        push(c + 6, 2'b01, 2'b00);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("step_stable0", stable_out[0], (k == 6));
        end
        repeat (6) @(negedge clk);

        // 3-cycle glitch on ch0: rejected
        async_in[0] = 1'b0;
        repeat (3) @(negedge clk);
        async_in[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("glitch_stable", stable_out, 2'b01);
        end
`ifdef LP_SYNC_GLITCH_CNT_EN
        chk("glitch_cnt0", glitch_cnt, 8'h01);
`endif

        // 4-cycle pulse on ch0: exactly at the threshold, passes both ways
        async_in[0] = 1'b0;
        c = cyc;
        push(c + 6, 2'b00, 2'b01);
        repeat (4) @(negedge clk);
        async_in[0] = 1'b1;
        push(c + 10, 2'b01, 2'b00);
        repeat (5) @(negedge clk);
        chk("bound_low", stable_out, 2'b00);
        repeat (4) @(negedge clk);
        chk("bound_high", stable_out, 2'b01);
        repeat (4) @(negedge clk);
`ifdef LP_SYNC_GLITCH_CNT_EN
        chk("bound_glitch", glitch_cnt, 8'h01);
`endif

        // ch1 toggles every 2 cycles while ch0 steps 1->0
        for (int i = 0; i < 80; i++) begin
            async_in[1] = ((i % 4) < 2);
            if (i == 0) begin
                async_in[0] = 1'b0;
                push(cyc + 6, 2'b00, 2'b01);
            end
            @(negedge clk);
            chk("toggle_hold1", stable_out[1], 1'b0);
        end
        async_in[1] = 1'b0;
        repeat (8) @(negedge clk);
        chk("toggle_stable", stable_out, 2'b00);
`ifdef LP_SYNC_GLITCH_CNT_EN
        chk("glitch_sat", glitch_cnt, 8'hF1);
`endif

        // Reset while ch0 count is at 2
        async_in[0] = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_stable", stable_out, 2'b11);
        chk("midrst_pulse",  {rise, fall, any_change}, 5'b0);
`ifdef LP_SYNC_GLITCH_CNT_EN
        chk("midrst_glitch", glitch_cnt, 8'h00);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        c = cyc;
        push(c + 6, 2'b00, 2'b10);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("postrst_stable", stable_out, (k < 6) ? 2'b11 : 2'b01);
        end
        repeat (8) @(negedge clk);

        chk("queue_empty", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
